// File: rtl/nvme_irq_pkg.sv
// Shared definitions for the NVMe interrupt arbiter.
//   state_t   : one-hot arbiter states
//   mm_clamp  : limits the host multiple-message-enable field to the
//               largest vector count the arbiter will ever use (2**5)
package nvme_irq_pkg;

   localparam int C_NUM_CQ_DEF    = 9;
   localparam int C_VEC_WIDTH_DEF = 8;
   localparam int C_MM_MAX        = 5;

   typedef enum logic [3:0] {
      S_IDLE     = 4'b0001,
      S_MSI_REQ  = 4'b0010,
      S_MSI_ACK  = 4'b0100,
      S_INTX_REQ = 4'b1000
   } state_t;

   function automatic logic [2:0] mm_clamp(input logic [2:0] mm);
      return (mm > 3'(C_MM_MAX)) ? 3'(C_MM_MAX) : mm;
   endfunction

endpackage

// File: rtl/nvme_rr_pick.sv
// Combinational round-robin picker.
//   req   : per-CQ request levels
//   last  : index granted most recently; the search starts just above it
//   grant : first requesting index found searching upward with wrap
//   any   : at least one request is pending
module nvme_rr_pick
   import nvme_irq_pkg::*;
#(
   parameter int C_NUM_CQ = C_NUM_CQ_DEF
) (
   input  logic [C_NUM_CQ-1:0]         req,
   input  logic [$clog2(C_NUM_CQ)-1:0] last,
   output logic [$clog2(C_NUM_CQ)-1:0] grant,
   output logic                        any
);

   localparam int IW = $clog2(C_NUM_CQ);

   // Walk from the farthest candidate (last itself) back to last+1 so the
   // final write is the closest requester after last.
   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      any   = 1'b0;
      for (int k = C_NUM_CQ; k >= 1; k--) begin
         idx = int'(last) + k;
         if (idx >= C_NUM_CQ) idx = idx - C_NUM_CQ;
         if (req[IW'(idx)]) begin
            grant = IW'(idx);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/nvme_irq_arb.sv
// Shares the PCIe core cfg_interrupt port among the CQ interrupt checkers.
//   pcie_user_clk / pcie_user_rst_n : clock, async active-low reset
//   pcie_msi_en            : 1 = MSI round-robin, 0 = INTx level OR
//   cfg_interrupt_mmenable : log2 of MSI vectors the host granted
//   cq_msi_irq_req/ack     : per-CQ MSI request level / one-cycle ack
//   cq_legacy_irq_req      : per-CQ INTx level
//   cfg_interrupt*         : request, assert flag, vector and ready of the core
//
// state      | meaning
// S_IDLE     | nothing in flight, choose next message
// S_MSI_REQ  | MSI for r_grant offered to core, wait for rdy
// S_MSI_ACK  | core took the MSI, pulse ack to r_grant
// S_INTX_REQ | INTx assert/deassert (r_target) offered, wait for rdy
module nvme_irq_arb
   import nvme_irq_pkg::*;
#(
   parameter int C_NUM_CQ    = C_NUM_CQ_DEF,
   parameter int C_VEC_WIDTH = C_VEC_WIDTH_DEF
) (
   input  logic                   pcie_user_clk,
   input  logic                   pcie_user_rst_n,
   input  logic                   pcie_msi_en,
   input  logic [2:0]             cfg_interrupt_mmenable,
   input  logic [C_NUM_CQ-1:0]    cq_msi_irq_req,
   output logic [C_NUM_CQ-1:0]    cq_msi_irq_ack,
   input  logic [C_NUM_CQ-1:0]    cq_legacy_irq_req,
   output logic                   cfg_interrupt,
   output logic                   cfg_interrupt_assert,
   output logic [C_VEC_WIDTH-1:0] cfg_interrupt_di,
   input  logic                   cfg_interrupt_rdy
);

   localparam int IW = $clog2(C_NUM_CQ);

   state_t                 state;
   state_t                 state_nxt;
   logic [IW-1:0]          r_grant;
   logic [IW-1:0]          r_rr_last;
   logic [IW-1:0]          pick_grant;
   logic                   pick_any;
   logic                   r_intx_on;
   logic                   r_target;
   logic [C_VEC_WIDTH-1:0] r_vec;
   logic [C_VEC_WIDTH-1:0] pick_vec;
   logic                   intx_off;
   logic                   msi_go;
   logic                   intx_go;

   nvme_rr_pick #(.C_NUM_CQ(C_NUM_CQ)) u_pick (
      .req   (cq_msi_irq_req),
      .last  (r_rr_last),
      .grant (pick_grant),
      .any   (pick_any)
   );

   // Vectors the host did not grant collapse onto vector 0.
   always_comb begin
      int lim;
      lim      = 1 << mm_clamp(cfg_interrupt_mmenable);
      pick_vec = '0;
      if (int'(pick_grant) < lim) pick_vec = C_VEC_WIDTH'(pick_grant);
   end

   // A pending deassert outranks everything so INTx never stays stuck on
   // across a switch to MSI.
   assign intx_off = r_intx_on && (pcie_msi_en || (cq_legacy_irq_req == '0));
   assign msi_go   = pcie_msi_en && pick_any;
   assign intx_go  = !pcie_msi_en && !r_intx_on && (cq_legacy_irq_req != '0);

   always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
      if (!pcie_user_rst_n) state <= S_IDLE;
      else                  state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (intx_off)     state_nxt = S_INTX_REQ;
            else if (msi_go)  state_nxt = S_MSI_REQ;
            else if (intx_go) state_nxt = S_INTX_REQ;
         end
         S_MSI_REQ:  if (cfg_interrupt_rdy) state_nxt = S_MSI_ACK;
         S_MSI_ACK:  state_nxt = S_IDLE;
         S_INTX_REQ: if (cfg_interrupt_rdy) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
      if (!pcie_user_rst_n) begin
         r_grant   <= '0;
         r_vec     <= '0;
         r_target  <= 1'b0;
         r_intx_on <= 1'b0;
         r_rr_last <= IW'(C_NUM_CQ - 1);
      end else begin
         if (state == S_IDLE) begin
            if (intx_off) begin
               r_target <= 1'b0;
            end else if (msi_go) begin
               r_grant <= pick_grant;
               r_vec   <= pick_vec;
            end else if (intx_go) begin
               r_target <= 1'b1;
            end
         end
         if (state == S_MSI_ACK) r_rr_last <= r_grant;
         if ((state == S_INTX_REQ) && cfg_interrupt_rdy) r_intx_on <= r_target;
      end
   end

   always_comb begin
      cfg_interrupt        = (state == S_MSI_REQ) || (state == S_INTX_REQ);
      cfg_interrupt_assert = (state == S_INTX_REQ) && r_target;
      cfg_interrupt_di     = (state == S_MSI_REQ) ? r_vec : '0;
      cq_msi_irq_ack       = '0;
      if (state == S_MSI_ACK) cq_msi_irq_ack[r_grant] = 1'b1;
   end

endmodule

// File: tb/tb_nvme_irq_arb.sv
// Bench for nvme_irq_arb: directed scenarios with literal expectations plus a
// randomized run, all watched every cycle by a transaction-level model.
module tb_nvme_irq_arb;

   localparam int N  = 9;
   localparam int VW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          msi_en = 1'b0;
   logic [2:0]    mm = 3'd0;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  ack;
   logic [N-1:0]  legacy = '0;
   logic          cfg_int;
   logic          cfg_as;
   logic [VW-1:0] di;
   logic          rdy = 1'b0;

   int total = 0;
   int bad   = 0;

   nvme_irq_arb #(.C_NUM_CQ(N), .C_VEC_WIDTH(VW)) dut (
      .pcie_user_clk          (clk),
      .pcie_user_rst_n        (rst_n),
      .pcie_msi_en            (msi_en),
      .cfg_interrupt_mmenable (mm),
      .cq_msi_irq_req         (req),
      .cq_msi_irq_ack         (ack),
      .cq_legacy_irq_req      (legacy),
      .cfg_interrupt          (cfg_int),
      .cfg_interrupt_assert   (cfg_as),
      .cfg_interrupt_di       (di),
      .cfg_interrupt_rdy      (rdy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   localparam int PH_IDLE = 0, PH_MSI_WAIT = 1, PH_ACK_DUE = 2, PH_INTX_WAIT = 3;
   int ph, m_last, m_grant, m_vec;
   bit m_intx_on, m_target;

   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      logic [N-1:0] t;
      for (int k = 1; k <= N; k++) begin
         t = r >> ((last + k) % N);
         if (t[0]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic int exp_vec(input int g, input logic [2:0] mmv);
      int m;
      m = (int'(mmv) > 5) ? 5 : int'(mmv);
      return (g < (1 << m)) ? g : 0;
   endfunction

   initial begin
      logic [N-1:0] ea;
      ph = PH_IDLE; m_last = N - 1; m_grant = 0; m_vec = 0;
      m_intx_on = 1'b0; m_target = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ph = PH_IDLE; m_last = N - 1; m_intx_on = 1'b0;
         end else begin
            ea = (ph == PH_ACK_DUE) ? (N'(1) << m_grant) : '0;
            check("m_cfg_int", int'(cfg_int), (ph == PH_MSI_WAIT || ph == PH_INTX_WAIT) ? 1 : 0);
            check("m_di", int'(di), (ph == PH_MSI_WAIT) ? m_vec : 0);
            check("m_assert", int'(cfg_as), (ph == PH_INTX_WAIT) ? int'(m_target) : 0);
            check("m_ack", int'(ack), int'(ea));
            case (ph)
               PH_IDLE: begin
                  if (m_intx_on && (msi_en || legacy == '0)) begin
                     ph = PH_INTX_WAIT; m_target = 1'b0;
                  end else if (msi_en && req != '0) begin
                     m_grant = rr_pick(req, m_last);
                     m_vec   = exp_vec(m_grant, mm);
                     ph      = PH_MSI_WAIT;
                  end else if (!msi_en && !m_intx_on && legacy != '0) begin
                     ph = PH_INTX_WAIT; m_target = 1'b1;
                  end
               end
               PH_MSI_WAIT:  if (rdy) ph = PH_ACK_DUE;
               PH_ACK_DUE:   begin m_last = m_grant; ph = PH_IDLE; end
               PH_INTX_WAIT: if (rdy) begin m_intx_on = m_target; ph = PH_IDLE; end
               default:      ph = PH_IDLE;
            endcase
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_outputs", int'({cfg_int, cfg_as, di, ack}), 0);
      rst_n = 1'b1;
   endtask

   task automatic wait_int(input string name);
      for (int k = 0; k < 40 && !cfg_int; k++) tick();
      check({name, "_req_seen"}, int'(cfg_int), 1);
   endtask

   task automatic do_msi(input int exp_g, input int exp_di, input int dly,
                         input string name, output int got);
      logic [N-1:0] t;
      wait_int(name);
      check({name, "_di"}, int'(di), exp_di);
      check({name, "_assert"}, int'(cfg_as), 0);
      for (int d = 0; d < dly; d++) begin
         tick();
         check({name, "_held"}, int'(cfg_int), 1);
      end
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      check({name, "_ack"}, int'(ack), 1 << exp_g);
      check({name, "_drop"}, int'(cfg_int), 0);
      got = -1;
      for (int i = 0; i < N; i++) begin
         t = ack >> i;
         if (t[0]) got = i;
      end
      req = req & ~ack;
      tick();
      check({name, "_ack_once"}, int'(ack), 0);
   endtask

   task automatic do_intx(input int exp_as, input string name);
      wait_int(name);
      check({name, "_assert"}, int'(cfg_as), exp_as);
      check({name, "_di"}, int'(di), 0);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      check({name, "_drop"}, int'(cfg_int), 0);
      check({name, "_no_ack"}, int'(ack), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int got, prev;
      int order [6] = '{0, 3, 5, 0, 3, 5};

      tick();
      do_reset();

      // 1: single MSI, rdy two cycles late
      msi_en = 1'b1; mm = 3'd3; req = N'(1) << 2;
      do_msi(2, 2, 2, "t1", got);

      // 2: round-robin fairness with immediate re-raise
      do_reset();
      req = 9'b000101001;
      prev = -1;
      for (int r = 0; r < 6; r++) begin
         do_msi(order[r], order[r], 0, "t2", got);
         check("t2_not_repeat", (got != prev) ? 1 : 0, 1);
         prev = got;
         req = req | 9'b000101001;
      end
      req = '0;
      tick(); tick(); tick();

      // 3: vector masking and mm clamp
      mm = 3'd1; req = N'(1) << 4;
      do_msi(4, 0, 1, "t3a", got);
      mm = 3'd7; req = N'(1) << 8;
      do_msi(8, 8, 1, "t3b", got);

      // 4: INTx level OR
      msi_en = 1'b0; legacy = N'(1) << 1;
      do_intx(1, "t4_assert");
      legacy = legacy | (N'(1) << 6);
      for (int k = 0; k < 6; k++) begin
         tick();
         check("t4_quiet", int'(cfg_int), 0);
      end
      legacy = '0;
      do_intx(0, "t4_deassert");

      // 5: switching to MSI deasserts INTx first
      legacy = N'(1) << 2;
      do_intx(1, "t5_assert");
      msi_en = 1'b1; req = N'(1);
      do_intx(0, "t5_deassert");
      do_msi(0, 0, 0, "t5_msi", got);
      legacy = '0;

      // 6: reset while an MSI is outstanding
      do_reset();
      mm = 3'd5; req = N'(1);
      do_msi(0, 0, 0, "t6_pre", got);
      req = 9'b000001001;
      wait_int("t6_pend");
      check("t6_pend_di", int'(di), 3);
      rst_n = 1'b0;
      #1;
      check("t6_async_drop", int'(cfg_int), 0);
      check("t6_no_ack", int'(ack), 0);
      tick();
      check("t6_no_ack2", int'(ack), 0);
      rst_n = 1'b1;
      do_msi(0, 0, 0, "t6_post", got);

      // randomized traffic, checked by the model
      do_reset();
      req = '0; legacy = '0; msi_en = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         tick();
         req = req & ~ack;
         if ($urandom_range(0, 199) == 0) req = req & ~(N'(1) << $urandom_range(0, N - 1));
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) req = req | (N'(1) << i);
            if ($urandom_range(0, 59) == 0) legacy = legacy ^ (N'(1) << i);
         end
         rdy = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 149) == 0) msi_en = !msi_en;
         if ($urandom_range(0, 99) == 0) mm = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 999) == 0) begin
            rst_n = 1'b0;
            tick();
            tick();
            rst_n = 1'b1;
         end
      end
      rdy = 1'b0;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
